// File: rtl/natv_timer.sv
// Native-IP bus timer: prescaled 32-bit up-counter with compare, sticky
// overflow flag and a registered level interrupt.
module natv_timer #(
    parameter int unsigned PSC_WIDTH    = 16,
    parameter int unsigned REG_ADDR_LSB = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        REG_CTRL = 3'd0,
        REG_PSC  = 3'd1,
        REG_CMP  = 3'd2,
        REG_CNT  = 3'd3,
        REG_STAT = 3'd4
    } reg_idx_e;

    logic                 en_q, ie_q, oneshot_q, ovf_q;
    logic [PSC_WIDTH-1:0] psc_q, pcnt_q;
    logic [31:0]          cmp_q, cnt_q, rdata_q;
    logic                 ready_q, irq_q;

    logic                 en_d, ie_d, oneshot_d, ovf_d;
    logic [PSC_WIDTH-1:0] psc_d, pcnt_d;
    logic [31:0]          cmp_d, cnt_d, rdata_d;

    reg_idx_e    reg_sel;
    logic        accept, wr_en, rd_en;
    logic        wr_ctrl, wr_psc, wr_cmp, wr_cnt, wr_stat;
    logic        tick, cmp_hit, ovf_set;
    logic [31:0] psc_ext, ctrl_cur, ctrl_merged, psc_merged, read_val;
    logic        unused_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    always_comb begin
        reg_sel = reg_idx_e'(addr_i[REG_ADDR_LSB +: 3]);
        accept  = valid_i & ~ready_q;
        wr_en   = accept & (|wstrb_i);
        rd_en   = accept & ~(|wstrb_i);
        wr_ctrl = wr_en & (reg_sel == REG_CTRL);
        wr_psc  = wr_en & (reg_sel == REG_PSC);
        wr_cmp  = wr_en & (reg_sel == REG_CMP);
        wr_cnt  = wr_en & (reg_sel == REG_CNT);
        wr_stat = wr_en & (reg_sel == REG_STAT);
    end

    always_comb begin
        tick    = en_q & (pcnt_q == psc_q);
        cmp_hit = tick & (cnt_q == cmp_q);
        // A bus write to CNT swallows the whole tick, overflow side effects included.
        ovf_set = cmp_hit & ~wr_cnt;
        if (wr_ctrl | wr_psc | ~en_q | tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PSC_WIDTH'(1);
        end
    end

    always_comb begin
        psc_ext                = '0;
        psc_ext[PSC_WIDTH-1:0] = psc_q;
        // Bus CTRL bytes merge over the post-one-shot value so the bus write wins.
        ctrl_cur    = {29'd0, oneshot_q, ie_q, en_q & ~(ovf_set & oneshot_q)};
        ctrl_merged = byte_merge(ctrl_cur, wdata_i, wstrb_i);
        psc_merged  = byte_merge(psc_ext, wdata_i, wstrb_i);

        {oneshot_d, ie_d, en_d} = wr_ctrl ? ctrl_merged[2:0] : ctrl_cur[2:0];
        psc_d = wr_psc ? psc_merged[PSC_WIDTH-1:0] : psc_q;
        cmp_d = wr_cmp ? byte_merge(cmp_q, wdata_i, wstrb_i) : cmp_q;

        if (wr_cnt) begin
            cnt_d = byte_merge(cnt_q, wdata_i, wstrb_i);
        end else if (tick) begin
            cnt_d = cmp_hit ? '0 : cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (wr_stat & wstrb_i[0] & wdata_i[0]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        read_val = '0;
        case (reg_sel)
            REG_CTRL: read_val = {29'd0, oneshot_q, ie_q, en_q};
            REG_PSC:  read_val = psc_ext;
            REG_CMP:  read_val = cmp_q;
            REG_CNT:  read_val = cnt_q;
            REG_STAT: read_val = {31'd0, ovf_q};
            default:  read_val = '0;
        endcase
        rdata_d = rd_en ? read_val : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            oneshot_q <= 1'b0;
            ovf_q     <= 1'b0;
            psc_q     <= '0;
            pcnt_q    <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            ie_q      <= ie_d;
            oneshot_q <= oneshot_d;
            ovf_q     <= ovf_d;
            psc_q     <= psc_d;
            pcnt_q    <= pcnt_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            ready_q   <= accept;
            irq_q     <= ovf_q & ie_q;
        end
    end

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign irq_o       = irq_q;
    assign unused_bits = ^{addr_i, ctrl_merged[31:3], psc_merged};

endmodule

// File: tb/tb_natv_timer.sv
// Self-checking bench for natv_timer: vector table, directed corner cases and
// randomized traffic compared every cycle against a transaction-level model.
module tb_natv_timer;

    localparam int unsigned PSC_W    = 16;
    localparam logic [31:0] PSC_MASK = 32'((64'd1 << PSC_W) - 64'd1);

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready, irq;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    natv_timer #(.PSC_WIDTH(PSC_W), .REG_ADDR_LSB(2)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .addr_i(addr),
        .wdata_i(wdata), .wstrb_i(wstrb), .rdata_o(rdata),
        .ready_o(ready), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        en;
        logic        ie;
        logic        os;
        logic        ovf;
        logic        ready;
        logic        irq;
        logic [31:0] psc;
        logic [31:0] cmp;
        logic [31:0] cnt;
        logic [31:0] pcnt;
        logic [31:0] rdata;
    } mstate_t;

    mstate_t ms = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                          input logic [3:0] st);
        logic [31:0] m;
        m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
        return (old_v & ~m) | (d & m);
    endfunction

    function automatic logic [31:0] reg_value(input mstate_t s, input int unsigned idx);
        case (idx)
            0: return {29'h0, s.os, s.ie, s.en};
            1: return s.psc;
            2: return s.cmp;
            3: return s.cnt;
            4: return {31'h0, s.ovf};
            default: return 32'h0;
        endcase
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic v, input logic [31:0] a,
                                           input logic [31:0] d, input logic [3:0] st);
        mstate_t     n;
        logic        acc, wr, tck, hit;
        int unsigned idx;
        logic [31:0] c;
        n    = s;
        acc  = v && !s.ready;
        wr   = acc && (st != 4'h0);
        idx  = int'(a[4:2]);
        tck  = s.en && (s.pcnt == s.psc);
        hit  = tck && (s.cnt == s.cmp);
        n.ready = acc;
        n.rdata = (acc && !wr) ? reg_value(s, idx) : 32'h0;
        n.irq   = s.ovf && s.ie;
        n.pcnt  = (s.en && !tck) ? s.pcnt + 32'd1 : 32'h0;
        if (tck) begin
            if (hit) begin
                n.cnt = 32'h0;
                n.ovf = 1'b1;
                if (s.os) n.en = 1'b0;
            end else begin
                n.cnt = s.cnt + 32'd1;
            end
        end
        if (wr) begin
            case (idx)
                0: begin
                    c = merge({29'h0, n.os, n.ie, n.en}, d, st);
                    n.os = c[2]; n.ie = c[1]; n.en = c[0];
                    n.pcnt = 32'h0;
                end
                1: begin n.psc = merge(s.psc, d, st) & PSC_MASK; n.pcnt = 32'h0; end
                2: n.cmp = merge(s.cmp, d, st);
                3: begin n.cnt = merge(s.cnt, d, st); n.ovf = s.ovf; n.en = s.en; end
                4: if (st[0] && d[0] && !hit) n.ovf = 1'b0;
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= '0;
        else     ms <= model_next(ms, valid, addr, wdata, wstrb);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_ready", 32'(ready), 32'(ms.ready));
            check("model_rdata", rdata, ms.rdata);
            check("model_irq", 32'(irq), 32'(ms.irq));
        end
    end

    // ---------------- bus helpers (entered at posedge+1) ----------------
    task automatic bus_xfer(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s,
                            input bit hold, output logic [31:0] r);
        int unsigned waited = 0;
        logic [31:0] a;
        a = $urandom();
        a[4:2] = idx;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        while (!ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("ready_seen", 32'(ready), 32'd1);
        check("ready_latency", waited, 32'd1);
        r = rdata;
        if (hold) begin
            @(negedge clk);
            check("no_second_ready", 32'(ready), 32'd0);
            valid = 1'b0; wstrb = '0;
        end else begin
            @(posedge clk); #1;
            valid = 1'b0; wstrb = '0;
        end
        if (hold) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d);
        logic [31:0] r;
        bus_xfer(idx, d, 4'hF, 1'b0, r);
        check("write_rdata_zero", r, 32'h0);
    endtask

    task automatic rd(input string name, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(idx, 32'h0, 4'h0, 1'b0, r);
        check(name, r, exp);
    endtask

    task automatic wait_cycles(input int unsigned n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mkv(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s,
                                 input logic [31:0] e, input string nm);
        vec_t v;
        v.idx = i; v.data = d; v.strb = s; v.exp = e; v.name = nm;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        logic [31:0] cnt_seq[5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

        vecs.push_back(mkv(3'd2, 32'h12345678, 4'b0101, 32'h0,        "cmp_wr_partial"));
        vecs.push_back(mkv(3'd2, 32'h0,        4'b0000, 32'h00340078, "cmp_rd_partial"));
        vecs.push_back(mkv(3'd3, 32'hAABBCCDD, 4'b1111, 32'h0,        "cnt_wr_full"));
        vecs.push_back(mkv(3'd3, 32'h0,        4'b0000, 32'hAABBCCDD, "cnt_rd_full"));
        vecs.push_back(mkv(3'd3, 32'h11223344, 4'b1000, 32'h0,        "cnt_wr_top"));
        vecs.push_back(mkv(3'd3, 32'h0,        4'b0000, 32'h11BBCCDD, "cnt_rd_top"));
        vecs.push_back(mkv(3'd1, 32'hFFFFFFFF, 4'b1111, 32'h0,        "psc_wr_all"));
        vecs.push_back(mkv(3'd1, 32'h0,        4'b0000, 32'h0000FFFF, "psc_rd_width"));
        vecs.push_back(mkv(3'd0, 32'hFFFFFFFF, 4'b1110, 32'h0,        "ctrl_wr_hi"));
        vecs.push_back(mkv(3'd0, 32'h0,        4'b0000, 32'h0,        "ctrl_rd_hi"));
        vecs.push_back(mkv(3'd0, 32'hFFFFFFF6, 4'b0001, 32'h0,        "ctrl_wr_lo"));
        vecs.push_back(mkv(3'd0, 32'h0,        4'b0000, 32'h6,        "ctrl_rd_lo"));
        vecs.push_back(mkv(3'd4, 32'hFFFFFFFF, 4'b1111, 32'h0,        "stat_wr"));
        vecs.push_back(mkv(3'd4, 32'h0,        4'b0000, 32'h0,        "stat_rd"));
        vecs.push_back(mkv(3'd5, 32'hDEADBEEF, 4'b1111, 32'h0,        "unmapped_wr"));
        vecs.push_back(mkv(3'd5, 32'h0,        4'b0000, 32'h0,        "unmapped_rd5"));
        vecs.push_back(mkv(3'd7, 32'h0,        4'b0000, 32'h0,        "unmapped_rd7"));
        vecs.push_back(mkv(3'd2, 32'h0,        4'b0000, 32'h00340078, "cmp_unchanged"));
        vecs.push_back(mkv(3'd0, 32'h0,        4'b1111, 32'h0,        "ctrl_clear"));
        vecs.push_back(mkv(3'd1, 32'h0,        4'b1111, 32'h0,        "psc_clear"));

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_xfer(3'(i), 32'h0, 4'h0, (i == 0), r);
            check("reset_read", r, 32'h0);
        end

        foreach (vecs[i]) begin
            bus_xfer(vecs[i].idx, vecs[i].data, vecs[i].strb, 1'b0, r);
            check(vecs[i].name, r, vecs[i].exp);
        end

        // periodic count: PSC=2, CMP=3
        wr(3'd1, 32'd2); wr(3'd2, 32'd3); wr(3'd3, 32'd0); wr(3'd0, 32'h3);
        for (int k = 0; k < 5; k++) begin
            rd("cnt_sequence", 3'd3, cnt_seq[k]);
            if (k == 3) check("irq_not_yet", 32'(irq), 32'd0);
            wait_cycles(1);
            if (k == 3) check("irq_one_cycle_after_ovf", 32'(irq), 32'd1);
        end
        rd("ovf_set", 3'd4, 32'd1);
        check("irq_held", 32'(irq), 32'd1);
        wr(3'd4, 32'h1);
        check("irq_cleared", 32'(irq), 32'd0);
        rd("ovf_cleared", 3'd4, 32'd0);

        // one-shot
        wr(3'd0, 32'h0); wr(3'd3, 32'h0); wr(3'd1, 32'h0); wr(3'd2, 32'd2);
        wr(3'd4, 32'h1); wr(3'd0, 32'h5);
        wait_cycles(4);
        rd("oneshot_en_off", 3'd0, 32'h4);
        rd("oneshot_cnt_zero", 3'd3, 32'h0);
        rd("oneshot_ovf", 3'd4, 32'h1);
        check("oneshot_irq_masked", 32'(irq), 32'd0);
        wait_cycles(3);
        rd("oneshot_cnt_hold", 3'd3, 32'h0);

        // bus CNT write on a tick edge
        wr(3'd0, 32'h0); wr(3'd3, 32'h0); wr(3'd2, 32'hFFFFFFFF); wr(3'd1, 32'd9);
        wr(3'd0, 32'h1);
        wait_cycles(8);
        wr(3'd3, 32'h10);
        rd("cnt_write_wins", 3'd3, 32'h10);

        // STAT clear on the overflow tick
        wr(3'd0, 32'h0); wr(3'd3, 32'h0); wr(3'd2, 32'h0); wr(3'd1, 32'd9);
        wr(3'd4, 32'h1); wr(3'd0, 32'h1);
        wait_cycles(8);
        wr(3'd4, 32'h1);
        rd("ovf_set_beats_clear", 3'd4, 32'h1);
        wr(3'd0, 32'h2);
        check("irq_before_reset", 32'(irq), 32'd1);

        // reset while a read is pending
        valid = 1'b1; addr = 32'h0; wstrb = 4'h0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_ready", 32'(ready), 32'd0);
        check("async_irq", 32'(irq), 32'd0);
        check("async_rdata", rdata, 32'h0);
        @(negedge clk);
        check("no_ready_in_reset", 32'(ready), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(ready), 32'd1);
        check("post_reset_ctrl", rdata, 32'h0);
        @(posedge clk); #1;
        valid = 1'b0;
        for (int i = 0; i < 5; i++) rd("post_reset_reg", 3'(i), 32'h0);

        // randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 400; t++) begin
            logic [2:0]  idx;
            logic [31:0] d;
            logic [3:0]  s;
            idx = 3'($urandom_range(0, 7));
            s   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            case (idx)
                3'd1:    d = $urandom_range(0, 3);
                3'd2:    d = $urandom_range(0, 6);
                3'd3:    d = $urandom_range(0, 6);
                default: d = $urandom();
            endcase
            bus_xfer(idx, d, s, ($urandom_range(0, 3) == 0), r);
            wait_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
